// File: rtl/mem_bus_ctrl.sv
// Memory-side controller for the cpu's shared memory bus. It serves read and write
// requests from an internal word array after a fixed latency. Read data stays on the bus until the cpu releases it.
//
// state    | meaning
// IDLE     | no access in flight, waiting for a request
// RD_WAIT  | read accepted, latency counter running
// WR_WAIT  | write accepted, latency counter running
// HOLD     | access complete, waiting for cpu to drop its request
// ERR_HOLD | readM and writeM seen together, waiting for both to drop

module mem_bus_ctrl #(
  parameter int WORD_SIZE = 16,
  parameter int ADDR_BITS = 8,
  parameter int LATENCY   = 2
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 readM,
  input  logic                 writeM,
  input  logic [WORD_SIZE-1:0] address,
  inout  wire  [WORD_SIZE-1:0] data,
  output logic                 ready,
  output logic                 busy,
  output logic                 err
);

  localparam int DEPTH = 1 << ADDR_BITS;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    RD_WAIT  = 3'd1,
    WR_WAIT  = 3'd2,
    HOLD     = 3'd3,
    ERR_HOLD = 3'd4
  } state_t;

  state_t               state_q, state_d;
  logic [3:0]           cnt_q, cnt_d;
  logic [WORD_SIZE-1:0] addr_q, wdata_q, rdata_q;
  logic                 ready_q, ready_d;
  logic                 err_q, err_d;
  logic                 last_rd_q;
  logic                 accept_rd, accept_wr, complete;
  logic                 req_any, addr_oor, drive_en;
  logic                 mem_we, rd_load;
  logic [ADDR_BITS-1:0] idx;
  logic [WORD_SIZE-1:0] mem [DEPTH];

  assign req_any = readM | writeM;
  assign idx     = addr_q[ADDR_BITS-1:0];

  generate
    if (ADDR_BITS < WORD_SIZE) begin : g_oor
      assign addr_oor = |addr_q[WORD_SIZE-1:ADDR_BITS];
    end else begin : g_no_oor
      assign addr_oor = 1'b0;
    end
  endgenerate

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    ready_d   = 1'b0;
    err_d     = 1'b0;
    accept_rd = 1'b0;
    accept_wr = 1'b0;
    complete  = 1'b0;
    case (state_q)
      IDLE: begin
        if (readM && writeM) begin
          state_d = ERR_HOLD;
          err_d   = 1'b1;
        end else if (readM) begin
          accept_rd = 1'b1;
          cnt_d     = 4'(LATENCY - 1);
          state_d   = RD_WAIT;
        end else if (writeM) begin
          accept_wr = 1'b1;
          cnt_d     = 4'(LATENCY - 1);
          state_d   = WR_WAIT;
        end
      end
      RD_WAIT, WR_WAIT: begin
        // Live request lines are ignored here except to pick HOLD vs IDLE.
        if (cnt_q == 4'd0) begin
          complete = 1'b1;
          ready_d  = 1'b1;
          err_d    = addr_oor;
          state_d  = req_any ? HOLD : IDLE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      HOLD: begin
        if (!req_any) state_d = IDLE;
      end
      ERR_HOLD: begin
        if (req_any) err_d = 1'b1;
        else         state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign mem_we  = complete && (state_q == WR_WAIT) && !addr_oor;
  assign rd_load = complete && (state_q == RD_WAIT);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      cnt_q     <= 4'd0;
      ready_q   <= 1'b0;
      err_q     <= 1'b0;
      last_rd_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ready_q <= ready_d;
      err_q   <= err_d;
      if (accept_rd || accept_wr) last_rd_q <= accept_rd;
    end
  end

  always_ff @(posedge clk) begin
    if (accept_rd || accept_wr) begin
      addr_q  <= address;
      wdata_q <= data;
    end
    if (rd_load) rdata_q <= addr_oor ? '0 : mem[idx];
  end

  // Array has no reset; a reset edge only blocks an in-flight write.
  always_ff @(posedge clk) begin
    if (reset_n && mem_we) mem[idx] <= wdata_q;
  end

  // Read data is driven in HOLD, or in the ready cycle of a read that went to IDLE.
  assign drive_en = last_rd_q && !writeM &&
                    ((state_q == HOLD) || ((state_q == IDLE) && ready_q));
  assign data     = drive_en ? rdata_q : {WORD_SIZE{1'bz}};

  assign ready = ready_q;
  assign err   = err_q;
  assign busy  = (state_q == RD_WAIT) || (state_q == WR_WAIT);

endmodule

// File: doc/mem_bus_ctrl.md
Name: mem_bus_ctrl

Overview:
- Memory-side controller on the cpu's shared memory bus. Consumes readM/writeM/address and the bidirectional data bus, and serves each request from an internal word-addressed array after a fixed access latency.
- Signals completion with a one-cycle ready pulse and holds read data on the bus until the cpu drops its request, which gives the multicycle datapath time to latch IR/MDR.
- Also flags illegal requests.

Parameters:
- WORD_SIZE, 16, data and address width.
- ADDR_BITS, 8, implemented address bits; array depth is 2^ADDR_BITS words.
- LATENCY, 2, clock edges from request acceptance to completion; legal range 1..15.

Ports:
- clk  input  1  clock; all state updates on posedge.
- reset_n  input  1  synchronous, active-low reset.
- readM  input  1  read request from the cpu, level, held until ready.
- writeM  input  1  write request from the cpu, level, held until ready.
- address  input  WORD_SIZE  word address from the cpu.
- data  inout  WORD_SIZE  shared data bus; cpu drives it on writes, this block drives it on reads.
- ready  output  1  one-cycle completion pulse.
- busy  output  1  high while an access is in flight (WAIT states).
- err  output  1  illegal request indicator.

Behaviour:
- Reset: on posedge clk with reset_n=0 the following take effect at that edge:
  - state=IDLE; ready=0; busy=0; err=0; latency counter=0.
  - data bus released (Z).
  - Array contents are not cleared.
  - A write that is in flight is dropped and its location is left unchanged.
- States: IDLE, RD_WAIT, WR_WAIT, HOLD, ERR_HOLD.
- IDLE, evaluated at each posedge:
  - readM=1 and writeM=1: go to ERR_HOLD, err=1. No access is performed.
  - readM=1 only: latch address; counter=LATENCY-1; busy=1; go to RD_WAIT.
  - writeM=1 only: latch address and sample the data bus at this edge; counter=LATENCY-1; busy=1; go to WR_WAIT.
  - Neither asserted: stay in IDLE.
- RD_WAIT / WR_WAIT:
  - Counter decrements on each edge.
  - On the edge where counter==0 the access completes:
    - Read: the array word (or 16'h0000 when out of range) is loaded into the output register.
    - Write: the array location is written (suppressed when out of range).
  - On that same edge: busy=0, ready=1 for exactly one cycle. err=1 for that same cycle if the latched address has any nonzero bit in [WORD_SIZE-1:ADDR_BITS].
  - Next state is HOLD if the request is still asserted at that edge, otherwise IDLE.
  - Net latency: request accepted at edge E0 means completion at edge E_LATENCY; ready is high between E_LATENCY and E_LATENCY+1.
- Request changes during WAIT (address, data, or deassertion) are ignored. The access completes with the latched values, and a dropped write still commits.
- HOLD:
  - ready=0.
  - For a read, the output register drives the data bus continuously from the completion edge until leaving HOLD.
  - Leave to IDLE on the first edge where both readM and writeM are 0; the bus is released at that edge.
  - A new request is therefore accepted no earlier than one edge after the request is dropped.
- ERR_HOLD: err stays high. Return to IDLE, with err=0, on the first edge where both requests are 0. The bus is never driven in this state.
- Bus drive: data is driven only when the previous access was a read and the state is HOLD, or during the ready cycle of a read that proceeds to IDLE. The data bus is never driven while writeM=1.
- Width: the array index is latched address[ADDR_BITS-1:0]; all data paths are WORD_SIZE.

Test Plan (LATENCY=2, ADDR_BITS=8):
- Write then read: writeM=1, address=16'h0012, data=16'hBEEF at E0 -> busy high for E0..E2; ready pulse after E2. Drop writeM, then readM=1 at 16'h0012 -> ready after edge +2, data=16'hBEEF held until readM=0, then Z.
- Illegal combination: readM=1 and writeM=1 together -> err=1 and no ready until both drop; a read of the targeted address afterwards returns its old value.
- Out of range: read at 16'h0100 -> ready and err together for one cycle, data=16'h0000. A write of 16'h1234 to 16'h0100 leaves mem[0x00] unchanged.
- Reset mid-write: write 16'hAAAA to 16'h0005, then reset_n=0 at E1 -> ready never pulses, outputs reset, data=Z; a subsequent read of 16'h0005 returns the prior value.
- Request dropped in WAIT: write 16'h5A5A to 16'h0007, then drop writeM at E1 -> ready still pulses after E2, state returns to IDLE with no HOLD, and mem[0x07]=16'h5A5A.
- Back-to-back: readM held continuously across completion -> no second access until readM has been low for at least one edge.
